// File: rtl/conv_layer_seq.sv
// conv_layer_seq
// Layer-level sequencer for the convolution datapath (PE -> ReLU -> optional
// maxpool). For every filter it clears the datapath, loads the K*K weights
// from the weight ROM, streams the whole feature map out of the input BRAM,
// collects the expected number of results and writes them to the output BRAM
// at a per-filter base address.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 start one layer (accepted only while idle)
//   o_busy, o_done, o_err   status: busy, one-cycle done pulse, sticky error
//   o_w_rd/o_w_addr         weight ROM read port, i_w_data 1 cycle later
//   o_w_load                weight-register shift strobe, aligned to i_w_data
//   o_fm_rd/o_fm_addr       feature-map BRAM read port, i_fm_data 1 cycle later
//   o_dp_clr                datapath clear
//   o_dp_en/o_dp_data       pixel stream into the datapath
//   i_dp_en/i_dp_data       result stream out of the datapath
//   o_ob_we/o_ob_addr/o_ob_data  output BRAM write port
module conv_layer_seq #(
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 8,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int MAXPOOL     = 0,
    parameter int NUM_FILT    = 4,
    parameter int DW          = 16,
    parameter int TIMEOUT     = 256,
    localparam int KK         = KERNEL_SIZE * KERNEL_SIZE,
    localparam int FM_PIX     = FM_SIZE * FM_SIZE,
    localparam int OUT_SIZE   = (FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE + 1,
    localparam int OUT_CNT    = (MAXPOOL != 0) ? (OUT_SIZE / 2) * (OUT_SIZE / 2)
                                               : OUT_SIZE * OUT_SIZE,
    localparam int WAW        = $clog2(NUM_FILT * KK),
    localparam int FAW        = $clog2(FM_PIX),
    localparam int OAW        = $clog2(NUM_FILT * OUT_CNT)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err,
    output logic           o_w_rd,
    output logic [WAW-1:0] o_w_addr,
    input  logic [17:0]    i_w_data,
    output logic           o_w_load,
    output logic           o_fm_rd,
    output logic [FAW-1:0] o_fm_addr,
    input  logic [DW-1:0]  i_fm_data,
    output logic           o_dp_clr,
    output logic           o_dp_en,
    output logic [DW-1:0]  o_dp_data,
    input  logic           i_dp_en,
    input  logic [DW-1:0]  i_dp_data,
    output logic           o_ob_we,
    output logic [OAW-1:0] o_ob_addr,
    output logic [DW-1:0]  o_ob_data
);
    localparam int IDX_MAX = (FM_PIX > KK) ? FM_PIX : KK;
    localparam int IW      = $clog2(IDX_MAX + 1);
    localparam int FW      = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    localparam int CW      = $clog2(OUT_CNT + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LDW, S_STREAM, S_DRAIN, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t         state_reg, state_next;
    logic [IW-1:0]  idx_reg, idx_next;
    logic [FW-1:0]  filt_reg, filt_next;
    logic [CW-1:0]  out_cnt_reg;
    logic [TW-1:0]  idle_cnt_reg;
    logic           err_reg;
    logic           w_load_reg;
    logic           dp_en_reg;
    logic           ob_we_reg;
    logic [OAW-1:0] ob_addr_reg;
    logic [DW-1:0]  ob_data_reg;

    logic w_rd, fm_rd, wb_window, res_accept, res_overflow, idle_hit, start_ok;

    // Weight words travel straight from the ROM to the datapath; the
    // sequencer only times them with o_w_load.
    logic unused_w_data;
    assign unused_w_data = ^i_w_data;

    // Read strobes: one read per cycle while idx is below the burst length.
    // idx runs one step past the burst so the delayed strobe can retire.
    assign w_rd         = (state_reg == S_LDW)    && (idx_reg < IW'(KK));
    assign fm_rd        = (state_reg == S_STREAM) && (idx_reg < IW'(FM_PIX));
    assign start_ok     = (state_reg == S_IDLE) && i_start;
    assign wb_window    = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
    assign res_accept   = wb_window && i_dp_en && (out_cnt_reg <  CW'(OUT_CNT));
    assign res_overflow = wb_window && i_dp_en && (out_cnt_reg >= CW'(OUT_CNT));
    // Fires on the TIMEOUT-th consecutive idle cycle in DRAIN.
    assign idle_hit     = (state_reg == S_DRAIN) && !i_dp_en
                          && (idle_cnt_reg == TW'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        filt_next  = filt_reg;
        case (state_reg)
            S_IDLE: begin
                idx_next = '0;
                if (i_start) begin
                    filt_next  = '0;
                    state_next = S_CLR;
                end
            end
            S_CLR: begin
                if (idx_reg == IW'(1)) begin
                    idx_next   = '0;
                    state_next = S_LDW;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            S_LDW: begin
                if (idx_reg == IW'(KK)) begin
                    idx_next   = '0;
                    state_next = S_STREAM;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            S_STREAM: begin
                if (idx_reg == IW'(FM_PIX)) begin
                    idx_next   = '0;
                    state_next = S_DRAIN;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            S_DRAIN: begin
                if (out_cnt_reg == CW'(OUT_CNT)) begin
                    state_next = S_NEXT;
                end else if (idle_hit) begin
                    state_next = S_ERR;
                end
            end
            S_NEXT: begin
                if (filt_reg == FW'(NUM_FILT - 1)) begin
                    state_next = S_DONE;
                end else begin
                    filt_next  = filt_reg + FW'(1);
                    state_next = S_CLR;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            filt_reg     <= '0;
            out_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
            err_reg      <= 1'b0;
            w_load_reg   <= 1'b0;
            dp_en_reg    <= 1'b0;
            ob_we_reg    <= 1'b0;
            ob_addr_reg  <= '0;
            ob_data_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            filt_reg   <= filt_next;
            w_load_reg <= w_rd;
            dp_en_reg  <= fm_rd;
            ob_we_reg  <= res_accept;

            if (state_reg == S_DRAIN && !i_dp_en) begin
                idle_cnt_reg <= idle_cnt_reg + TW'(1);
            end else begin
                idle_cnt_reg <= '0;
            end

            // Idle also clears the count so an aborted (timed-out) layer
            // does not leak into the next one.
            if (state_reg == S_IDLE || state_reg == S_NEXT) begin
                out_cnt_reg <= '0;
            end else if (res_accept) begin
                out_cnt_reg <= out_cnt_reg + CW'(1);
                ob_addr_reg <= OAW'(32'(filt_reg) * OUT_CNT + 32'(out_cnt_reg));
                ob_data_reg <= i_dp_data;
            end

            if (start_ok) begin
                err_reg <= 1'b0;
            end else if (res_overflow || idle_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign o_busy    = (state_reg != S_IDLE) && (state_reg != S_DONE) && (state_reg != S_ERR);
    assign o_done    = (state_reg == S_DONE);
    assign o_err     = err_reg;
    assign o_dp_clr  = (state_reg == S_CLR);
    assign o_w_rd    = w_rd;
    assign o_w_addr  = w_rd ? WAW'(32'(filt_reg) * KK + 32'(idx_reg)) : '0;
    assign o_w_load  = w_load_reg;
    assign o_fm_rd   = fm_rd;
    assign o_fm_addr = fm_rd ? FAW'(idx_reg) : '0;
    assign o_dp_en   = dp_en_reg;
    // BRAM data arrives in the cycle after the read, i.e. together with the
    // delayed strobe; it is passed through and forced to zero when invalid.
    assign o_dp_data = dp_en_reg ? i_fm_data : '0;
    assign o_ob_we   = ob_we_reg;
    assign o_ob_addr = ob_addr_reg;
    assign o_ob_data = ob_data_reg;
endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq: instance A (K=3, FM=4, 2 filters, no
// pool, TIMEOUT=16) covers normal run, start-while-busy, timeout, overflow
// and mid-load reset; instance B (FM=6, maxpool) covers pooled addressing.
module tb_conv_layer_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic        start_a = 1'b0;
    logic        busy_a, done_a, err_a, w_rd_a, w_load_a, fm_rd_a, dp_clr_a, dp_en_a, ob_we_a;
    logic [4:0]  w_addr_a;
    logic [3:0]  fm_addr_a;
    logic [2:0]  ob_addr_a;
    logic [17:0] w_data_a = '0;
    logic [15:0] fm_data_a = '0, dp_data_a, ob_data_a;
    logic        res_en_a = 1'b0;
    logic [15:0] res_data_a = '0;

    conv_layer_seq #(.KERNEL_SIZE(3), .FM_SIZE(4), .PADDING(0), .STRIDE(1), .MAXPOOL(0),
                     .NUM_FILT(2), .DW(16), .TIMEOUT(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
        .o_err(err_a), .o_w_rd(w_rd_a), .o_w_addr(w_addr_a), .i_w_data(w_data_a),
        .o_w_load(w_load_a), .o_fm_rd(fm_rd_a), .o_fm_addr(fm_addr_a), .i_fm_data(fm_data_a),
        .o_dp_clr(dp_clr_a), .o_dp_en(dp_en_a), .o_dp_data(dp_data_a), .i_dp_en(res_en_a),
        .i_dp_data(res_data_a), .o_ob_we(ob_we_a), .o_ob_addr(ob_addr_a), .o_ob_data(ob_data_a));

    // ROM/BRAM models: registered read, contents derived from the address.
    always @(posedge clk) begin
        w_data_a  <= 18'(w_addr_a) + 18'd500;
        fm_data_a <= 16'(fm_addr_a) + 16'd1000;
    end

    // Datapath model A: after the 16th pixel of a filter, emits n_res[filter]
    // results back-to-back with data 256*(filter+1)+k.
    int n_res [2];
    bit model_clr = 1'b0;
    int m_cnt = 0, m_pend = 0, m_filt = 0, m_cur = 0, m_k = 0;
    always @(posedge clk) begin
        if (rst || model_clr) begin
            m_cnt <= 0; m_pend <= 0; m_filt <= 0; m_cur <= 0; m_k <= 0;
            res_en_a <= 1'b0;
        end else begin
            res_en_a <= 1'b0;
            if (m_pend > 0) begin
                res_en_a   <= 1'b1;
                res_data_a <= 16'(256 * (m_cur + 1) + m_k);
                m_k        <= m_k + 1;
                m_pend     <= m_pend - 1;
            end
            if (dp_en_a) begin
                if (m_cnt == 15) begin
                    m_cnt  <= 0;
                    m_cur  <= m_filt;
                    m_filt <= m_filt + 1;
                    m_pend <= (m_filt < 2) ? n_res[m_filt] : 0;
                    m_k    <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    // Monitor A (negative edge).
    int wq[$];
    int obq_addr[$];
    int obq_data[$];
    int fm_n = 0, fm_bad = 0, load_bad = 0, dp_bad = 0, done_n = 0, clr_n = 0, last_res_cyc = 0;
    logic prev_w_rd = 1'b0, prev_fm_rd = 1'b0;
    logic [3:0] prev_fm_addr = '0;
    always @(negedge clk) begin
        if (w_rd_a) wq.push_back(int'(w_addr_a));
        if (w_load_a !== prev_w_rd) load_bad++;
        if (dp_en_a !== prev_fm_rd) dp_bad++;
        if (dp_en_a && (dp_data_a !== 16'(prev_fm_addr) + 16'd1000)) dp_bad++;
        if (fm_rd_a) begin
            if (fm_addr_a !== 4'(fm_n % 16)) fm_bad++;
            fm_n++;
        end
        if (ob_we_a) begin
            obq_addr.push_back(int'(ob_addr_a));
            obq_data.push_back(int'(ob_data_a));
        end
        if (done_a) done_n++;
        if (dp_clr_a) clr_n++;
        if (res_en_a) last_res_cyc = cyc;
        prev_w_rd    = w_rd_a;
        prev_fm_rd   = fm_rd_a;
        prev_fm_addr = fm_addr_a;
    end

    // ---------------- instance B (maxpool) ----------------
    logic        start_b = 1'b0;
    logic        busy_b, done_b, err_b, w_rd_b, w_load_b, fm_rd_b, dp_clr_b, dp_en_b, ob_we_b;
    logic [4:0]  w_addr_b;
    logic [5:0]  fm_addr_b;
    logic [2:0]  ob_addr_b;
    logic [17:0] w_data_b = '0;
    logic [15:0] fm_data_b = '0, dp_data_b, ob_data_b;
    logic        res_en_b = 1'b0;
    logic [15:0] res_data_b = '0;

    conv_layer_seq #(.KERNEL_SIZE(3), .FM_SIZE(6), .PADDING(0), .STRIDE(1), .MAXPOOL(1),
                     .NUM_FILT(2), .DW(16), .TIMEOUT(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
        .o_err(err_b), .o_w_rd(w_rd_b), .o_w_addr(w_addr_b), .i_w_data(w_data_b),
        .o_w_load(w_load_b), .o_fm_rd(fm_rd_b), .o_fm_addr(fm_addr_b), .i_fm_data(fm_data_b),
        .o_dp_clr(dp_clr_b), .o_dp_en(dp_en_b), .o_dp_data(dp_data_b), .i_dp_en(res_en_b),
        .i_dp_data(res_data_b), .o_ob_we(ob_we_b), .o_ob_addr(ob_addr_b), .o_ob_data(ob_data_b));

    always @(posedge clk) begin
        w_data_b  <= 18'(w_addr_b);
        fm_data_b <= 16'(fm_addr_b);
    end

    int b_cnt = 0, b_pend = 0, b_k = 0;
    always @(posedge clk) begin
        if (rst) begin
            b_cnt <= 0; b_pend <= 0; b_k <= 0;
            res_en_b <= 1'b0;
        end else begin
            res_en_b <= 1'b0;
            if (b_pend > 0) begin
                res_en_b   <= 1'b1;
                res_data_b <= 16'(b_k + 7);
                b_k        <= b_k + 1;
                b_pend     <= b_pend - 1;
            end
            if (dp_en_b) begin
                if (b_cnt == 35) begin
                    b_cnt  <= 0;
                    b_pend <= 4;
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
        end
    end

    int obq_b[$];
    int done_b_n = 0, fm_b_n = 0;
    always @(negedge clk) begin
        if (ob_we_b) obq_b.push_back(int'(ob_addr_b));
        if (done_b) done_b_n++;
        if (fm_rd_b) fm_b_n++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wq.delete(); obq_addr.delete(); obq_data.delete();
        fm_n = 0; fm_bad = 0; load_bad = 0; dp_bad = 0; done_n = 0; clr_n = 0;
    endtask

    task automatic reset_model(input int r0, input int r1);
        n_res[0] = r0;
        n_res[1] = r1;
        @(negedge clk); model_clr = 1'b1;
        @(negedge clk); model_clr = 1'b0;
    endtask

    task automatic pulse_start_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_w_seq(input string tag);
        check({tag, "_w_count"}, wq.size(), 18);
        for (int i = 0; i < 18; i++)
            check({tag, "_w_addr"}, (i < wq.size()) ? wq[i] : -1, i);
    endtask

    task automatic check_ob_seq(input string tag);
        check({tag, "_ob_count"}, obq_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_ob_addr"}, (i < obq_addr.size()) ? obq_addr[i] : -1, i);
            check({tag, "_ob_data"}, (i < obq_data.size()) ? obq_data[i] : -1,
                  256 * (i / 4 + 1) + (i % 4));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int diff;
        n_res[0] = 4;
        n_res[1] = 4;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_w_rd", w_rd_a, 0);
        check("rst_fm_rd", fm_rd_a, 0);
        check("rst_dp_clr", dp_clr_a, 0);
        check("rst_ob_we", ob_we_a, 0);
        rst = 1'b0;
        clear_logs();

        // 1: normal layer, 4 results per filter
        pulse_start_a();
        check("t1_busy", busy_a, 1);
        wait_done_a(500, ok);
        check("t1_done_seen", ok, 1);
        start_a = 1'b1;             // start while o_done is high: ignored
        @(negedge clk);
        start_a = 1'b0;
        check("t1_start_in_done", busy_a, 0);
        repeat (3) @(negedge clk);
        check_w_seq("t1");
        check("t1_fm_count", fm_n, 32);
        check("t1_fm_addr_bad", fm_bad, 0);
        check("t1_w_load_bad", load_bad, 0);
        check("t1_dp_bad", dp_bad, 0);
        check_ob_seq("t1");
        check("t1_done_count", done_n, 1);
        check("t1_clr_cycles", clr_n, 4);
        check("t1_err", err_a, 0);

        // 2: start re-asserted during STREAM
        reset_model(4, 4);
        clear_logs();
        pulse_start_a();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fm_rd_a) begin ok = 1'b1; break; end
        end
        check("t2_stream_seen", ok, 1);
        start_a = 1'b1;
        repeat (5) @(negedge clk);
        start_a = 1'b0;
        wait_done_a(500, ok);
        check("t2_done_seen", ok, 1);
        repeat (5) @(negedge clk);
        check_w_seq("t2");
        check("t2_fm_count", fm_n, 32);
        check("t2_done_count", done_n, 1);
        check("t2_ob_count", obq_addr.size(), 8);

        // 3: datapath stalls after 2 results -> timeout
        reset_model(2, 4);
        clear_logs();
        pulse_start_a();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (err_a) begin ok = 1'b1; break; end
        end
        check("t3_err_seen", ok, 1);
        diff = cyc - last_res_cyc;
        check("t3_timeout_delay_16to18", (diff >= 16 && diff <= 18), 1);
        check("t3_busy", busy_a, 0);
        repeat (5) @(negedge clk);
        check("t3_no_done", done_n, 0);
        check("t3_ob_count", obq_addr.size(), 2);
        check("t3_err_sticky", err_a, 1);
        reset_model(4, 4);
        clear_logs();
        pulse_start_a();
        check("t3_err_cleared", err_a, 0);
        check("t3_busy_again", busy_a, 1);
        wait_done_a(500, ok);
        check("t3_rerun_done", ok, 1);
        repeat (3) @(negedge clk);
        check_ob_seq("t3");

        // 4: five results for filter 0 -> overflow, layer still completes
        reset_model(5, 4);
        clear_logs();
        pulse_start_a();
        wait_done_a(500, ok);
        check("t4_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        check_ob_seq("t4");
        check("t4_err", err_a, 1);
        check("t4_done_count", done_n, 1);

        // 5: reset in the middle of the weight load
        reset_model(4, 4);
        clear_logs();
        pulse_start_a();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wq.size() >= 3) begin ok = 1'b1; break; end
        end
        check("t5_ldw_seen", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_w_rd", w_rd_a, 0);
        check("t5_w_load", w_load_a, 0);
        check("t5_fm_rd", fm_rd_a, 0);
        check("t5_busy", busy_a, 0);
        check("t5_dp_clr", dp_clr_a, 0);
        check("t5_ob_we", ob_we_a, 0);
        rst = 1'b0;
        clear_logs();
        pulse_start_a();
        wait_done_a(500, ok);
        check("t5_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        check_w_seq("t5");
        check("t5_err", err_a, 0);

        // 6: maxpool instance, OUT_CNT = 4
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done_b) begin ok = 1'b1; break; end
        end
        check("t6_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        check("t6_ob_count", obq_b.size(), 8);
        for (int i = 0; i < 8; i++)
            check("t6_ob_addr", (i < obq_b.size()) ? obq_b[i] : -1, i);
        check("t6_fm_count", fm_b_n, 72);
        check("t6_done_count", done_b_n, 1);
        check("t6_err", err_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_layer_seq.md
Name: conv_layer_seq

Overview:
Layer-level sequencer for the convolution datapath (PE -> ReLU -> optional maxpool). For each of NUM_FILT filters it clears the datapath, loads K*K weights from a weight ROM, and streams the feature map from an input BRAM. It then collects the expected number of results and writes them to an output BRAM at per-filter base addresses. It is the single master of datapath enable, clear and writeback.

Parameters:
KERNEL_SIZE, 3, kernel width/height (K)
FM_SIZE, 8, input feature-map width/height
PADDING, 0, datapath padding (used only for OUT_SIZE)
STRIDE, 1, datapath stride (used only for OUT_SIZE)
MAXPOOL, 0, 1 = datapath output is 2x2 maxpooled
NUM_FILT, 4, filters per layer
DW, 16, data width
TIMEOUT, 256, max idle cycles allowed while draining results

Derived values:
- OUT_SIZE = (FM_SIZE-K+2*PADDING)/STRIDE+1
- OUT_CNT = MAXPOOL ? (OUT_SIZE/2)^2 : OUT_SIZE^2

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_start  in  1  start one layer; ignored while o_busy
o_busy  out  1  high from accepted start until DONE/ERR
o_done  out  1  one-cycle pulse, layer complete
o_err  out  1  sticky error (timeout or result overflow)
o_w_rd  out  1  weight ROM read strobe
o_w_addr  out  clog2(NUM_FILT*K*K)  weight ROM address
i_w_data  in  18  weight data, valid 1 cycle after o_w_rd
o_w_load  out  1  shift i_w_data into the datapath weight register
o_fm_rd  out  1  FM BRAM read strobe
o_fm_addr  out  clog2(FM_SIZE^2)  FM BRAM address
i_fm_data  in  DW  FM data, valid 1 cycle after o_fm_rd
o_dp_clr  out  1  datapath clear (drives PE/maxpool reset)
o_dp_en  out  1  pixel valid to the datapath
o_dp_data  out  DW  pixel to the datapath
i_dp_en  in  1  datapath result valid
i_dp_data  in  DW  datapath result
o_ob_we  out  1  output BRAM write enable
o_ob_addr  out  clog2(NUM_FILT*OUT_CNT)  output BRAM address
o_ob_data  out  DW  output BRAM write data

Behaviour:
Reset values:
- All outputs 0; state IDLE; all counters 0.
- A reset mid-operation aborts immediately; no further reads or writes are issued.

States:
- IDLE: o_busy=0. On i_start: filt=0, clear o_err, go to CLR.
- CLR: o_dp_clr=1 for exactly 2 cycles, then LDW.
- LDW: issue K*K consecutive reads at o_w_addr = filt*K*K + idx, idx = 0..K*K-1.
  - o_w_load is o_w_rd delayed 1 cycle, and accompanies i_w_data.
  - Go to STREAM in the cycle after the last o_w_load.
- STREAM: issue FM_SIZE^2 consecutive reads at o_fm_addr = idx, one per cycle.
  - o_dp_en/o_dp_data are o_fm_rd/i_fm_data delayed 1 cycle.
  - After the last o_dp_en, go to DRAIN.
- DRAIN: wait until out_cnt == OUT_CNT, then NEXT.
  - idle_cnt increments each cycle without i_dp_en and resets on i_dp_en.
  - idle_cnt == TIMEOUT -> ERR.
- NEXT: out_cnt=0. If filt == NUM_FILT-1 -> DONE, else filt++ and go to CLR.
- DONE: o_done=1 for one cycle -> IDLE.
- ERR: o_err=1 (sticky), o_busy=0 -> IDLE. o_done is not pulsed.

Writeback:
- Active in STREAM and DRAIN only.
- On i_dp_en with out_cnt < OUT_CNT, in the next cycle: o_ob_we=1, o_ob_addr = filt*OUT_CNT + out_cnt, o_ob_data = i_dp_data; out_cnt++.
- i_dp_en with out_cnt == OUT_CNT: no write, o_err=1, and the sequence still finishes normally.
- i_dp_en outside STREAM/DRAIN is ignored.

Boundaries:
- i_start during busy is ignored.
- i_start in the same cycle as o_done is ignored; a start is accepted only in IDLE.
- Addresses never exceed their ranges; no wrap-around is required.
- A result arriving in the same cycle as the DRAIN->NEXT transition cannot occur legally; it is counted as an overflow.

Test Plan:
- K=3, FM=4, NUM_FILT=2, MAXPOOL=0 (OUT_CNT=4), datapath model returns 4 results per filter -> per filter: 9 weight reads at addresses 0..8, then 9..17; 16 FM reads per filter; writes at ob_addr 0..3 and 4..7; o_done pulses once; o_err=0.
- Same configuration, i_start re-asserted during STREAM -> no restart, address sequence unchanged, single o_done.
- Datapath model stops after 2 results, TIMEOUT=16 -> ERR 16 cycles after the last result; o_err=1; o_busy=0; no o_done; next i_start clears o_err.
- Datapath model returns 5 results for filter 0 -> only addresses 0..3 written; o_err=1; filter 1 still processed; o_done pulses.
- MAXPOOL=1, FM=6, K=3 (OUT_SIZE=4, OUT_CNT=4) -> ob_addr per filter = filt*4 + 0..3.
- i_rst asserted mid-LDW -> next cycle: all strobes 0, o_busy=0; a fresh i_start restarts from weight address 0.
